// File: rtl/ex_mem.sv
// ----------------------------------------------------------------------------
// ex_mem : EX -> MEM pipeline register of the five-stage MIPS32 core.
//
// Captures the EX-stage results on every rising edge and presents them to the
// MEM stage one cycle later. It also returns the MADD/MSUB intermediate
// product and step counter to EX, so a two-cycle multiply-accumulate keeps
// its partial result across the stall cycle. Bubbles inserted into MEM are
// counted in a saturating counter for performance monitoring.
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output.
//
// Ports
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous reset, active low
//   flush      in   exception flush; clears the stage contents
//   stall      in   global stall vector (bit 3 = EX held, bit 4 = MEM held)
//   ex_wd      in   destination register from EX
//   ex_wreg    in   register write enable from EX
//   ex_wdata   in   result data from EX
//   ex_whilo   in   HI/LO write enable from EX
//   ex_hi      in   HI value from EX
//   ex_lo      in   LO value from EX
//   hilo_i     in   MADD/MSUB intermediate product from EX
//   cnt_i      in   MADD/MSUB step counter from EX
//   mem_wd     out  registered destination register to MEM
//   mem_wreg   out  registered register write enable to MEM
//   mem_wdata  out  registered result data to MEM
//   mem_whilo  out  registered HI/LO write enable to MEM
//   mem_hi     out  registered HI to MEM
//   mem_lo     out  registered LO to MEM
//   hilo_o     out  intermediate product returned to EX
//   cnt_o      out  step counter returned to EX
//   bubble_cnt out  saturating count of bubbles inserted into MEM
//
// Stall handshake: the controller never holds MEM while EX advances
// (stall[3]=0 with stall[4]=1). If it happens anyway the stage advances.
// ----------------------------------------------------------------------------
module ex_mem #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BCNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [5:0]          stall,
   input  logic [ADDR_W-1:0]   ex_wd,
   input  logic                ex_wreg,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic                ex_whilo,
   input  logic [DATA_W-1:0]   ex_hi,
   input  logic [DATA_W-1:0]   ex_lo,
   input  logic [2*DATA_W-1:0] hilo_i,
   input  logic [1:0]          cnt_i,
   output logic [ADDR_W-1:0]   mem_wd,
   output logic                mem_wreg,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_whilo,
   output logic [DATA_W-1:0]   mem_hi,
   output logic [DATA_W-1:0]   mem_lo,
   output logic [2*DATA_W-1:0] hilo_o,
   output logic [1:0]          cnt_o,
   output logic [BCNT_W-1:0]   bubble_cnt
);

   logic [ADDR_W-1:0]   wd_q,    wd_d;
   logic                wreg_q,  wreg_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                whilo_q, whilo_d;
   logic [DATA_W-1:0]   hi_q,    hi_d;
   logic [DATA_W-1:0]   lo_q,    lo_d;
   logic [2*DATA_W-1:0] hilo_q,  hilo_d;
   logic [1:0]          cnt_q,   cnt_d;
   logic [BCNT_W-1:0]   bcnt_q,  bcnt_d;

   logic ex_stall;
   logic mem_stall;
   logic bubble;

   // Only the EX and MEM stall bits matter to this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[2:0]};

   assign ex_stall  = stall[3];
   assign mem_stall = stall[4];
   // EX is held but MEM keeps moving, so MEM must be fed a NOP.
   assign bubble    = ex_stall && !mem_stall;

   always_comb begin
      // Default: hold every register (the EX+MEM stalled case).
      wd_d    = wd_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      whilo_d = whilo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hilo_d  = hilo_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;

      if (flush) begin
         // Discard the stage; the bubble counter is performance state and survives.
         wd_d    = '0;
         wreg_d  = 1'b0;
         wdata_d = '0;
         whilo_d = 1'b0;
         hi_d    = '0;
         lo_d    = '0;
         hilo_d  = '0;
         cnt_d   = '0;
      end else if (bubble) begin
         wd_d    = '0;
         wreg_d  = 1'b0;
         wdata_d = '0;
         whilo_d = 1'b0;
         hi_d    = '0;
         lo_d    = '0;
         // Loop the multiply-accumulate partial result back to EX.
         hilo_d  = hilo_i;
         cnt_d   = cnt_i;
         if (bcnt_q != {BCNT_W{1'b1}}) begin
            bcnt_d = bcnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
         end
      end else if (!ex_stall) begin
         wd_d    = ex_wd;
         wreg_d  = ex_wreg;
         wdata_d = ex_wdata;
         whilo_d = ex_whilo;
         hi_d    = ex_hi;
         lo_d    = ex_lo;
         hilo_d  = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q    <= '0;
         wreg_q  <= 1'b0;
         wdata_q <= '0;
         whilo_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         hilo_q  <= '0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
      end else begin
         wd_q    <= wd_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         whilo_q <= whilo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hilo_q  <= hilo_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign mem_wd     = wd_q;
   assign mem_wreg   = wreg_q;
   assign mem_wdata  = wdata_q;
   assign mem_whilo  = whilo_q;
   assign mem_hi     = hi_q;
   assign mem_lo     = lo_q;
   assign hilo_o     = hilo_q;
   assign cnt_o      = cnt_q;
   assign bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// ----------------------------------------------------------------------------
// tb_ex_mem : directed, table-driven bench for ex_mem.
//
// A table of {inputs, expected outputs} records is applied one per clock,
// followed by hand-written sequences for the MADD/MSUB loop-back, the
// asynchronous reset and bubble-counter saturation. A second instance with a
// 4-bit bubble counter shares the stimulus and is used for saturation.
// ----------------------------------------------------------------------------
module tb_ex_mem;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [5:0]  stall;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic        ex_whilo;
   logic [31:0] ex_hi;
   logic [31:0] ex_lo;
   logic [63:0] hilo_i;
   logic [1:0]  cnt_i;

   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic [63:0] hilo_o;
   logic [1:0]  cnt_o;
   logic [15:0] bubble_cnt;

   logic [4:0]  s_mem_wd;
   logic        s_mem_wreg;
   logic [31:0] s_mem_wdata;
   logic        s_mem_whilo;
   logic [31:0] s_mem_hi;
   logic [31:0] s_mem_lo;
   logic [63:0] s_hilo_o;
   logic [1:0]  s_cnt_o;
   logic [3:0]  s_bubble_cnt;

   int n_vec  = 0;
   int n_fail = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   ex_mem dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .hilo_o(hilo_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
   );

   ex_mem #(.BCNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(s_mem_wd), .mem_wreg(s_mem_wreg), .mem_wdata(s_mem_wdata),
      .mem_whilo(s_mem_whilo), .mem_hi(s_mem_hi), .mem_lo(s_mem_lo),
      .hilo_o(s_hilo_o), .cnt_o(s_cnt_o), .bubble_cnt(s_bubble_cnt)
   );

   // The controller must never hold MEM while EX advances.
   always @(posedge clk) begin
      if (rst) begin
         assert (!(!stall[3] && stall[4]))
            else $error("illegal stall combination %b", stall);
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic        flush;
      logic [5:0]  stall;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] hilo;
      logic [1:0]  cnt;
      logic [4:0]  e_wd;
      logic        e_wreg;
      logic [31:0] e_wdata;
      logic        e_whilo;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
      logic [63:0] e_hilo;
      logic [1:0]  e_cnt;
      logic [15:0] e_bcnt;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic fl, input logic [5:0] st, input logic [4:0] wd, input logic wr,
      input logic [31:0] wdat, input logic wh, input logic [31:0] hi, input logic [31:0] lo,
      input logic [63:0] hl, input logic [1:0] cn,
      input logic [4:0] ewd, input logic ewr, input logic [31:0] ewdat, input logic ewh,
      input logic [31:0] ehi, input logic [31:0] elo, input logic [63:0] ehl,
      input logic [1:0] ecn, input logic [15:0] ebc);
      vec_t v;
      v.flush = fl;  v.stall = st;  v.wd = wd;   v.wreg = wr;  v.wdata = wdat;
      v.whilo = wh;  v.hi = hi;     v.lo = lo;   v.hilo = hl;  v.cnt = cn;
      v.e_wd = ewd;  v.e_wreg = ewr; v.e_wdata = ewdat; v.e_whilo = ewh;
      v.e_hi = ehi;  v.e_lo = elo;  v.e_hilo = ehl; v.e_cnt = ecn; v.e_bcnt = ebc;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input vec_t v);
      flush    = v.flush;
      stall    = v.stall;
      ex_wd    = v.wd;
      ex_wreg  = v.wreg;
      ex_wdata = v.wdata;
      ex_whilo = v.whilo;
      ex_hi    = v.hi;
      ex_lo    = v.lo;
      hilo_i   = v.hilo;
      cnt_i    = v.cnt;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t v);
      chk({tag, ".mem_wd"},     64'(mem_wd),     64'(v.e_wd));
      chk({tag, ".mem_wreg"},   64'(mem_wreg),   64'(v.e_wreg));
      chk({tag, ".mem_wdata"},  64'(mem_wdata),  64'(v.e_wdata));
      chk({tag, ".mem_whilo"},  64'(mem_whilo),  64'(v.e_whilo));
      chk({tag, ".mem_hi"},     64'(mem_hi),     64'(v.e_hi));
      chk({tag, ".mem_lo"},     64'(mem_lo),     64'(v.e_lo));
      chk({tag, ".hilo_o"},     hilo_o,          v.e_hilo);
      chk({tag, ".cnt_o"},      64'(cnt_o),      64'(v.e_cnt));
      chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(v.e_bcnt));
   endtask

   // Apply at the falling edge, check 1 time unit after the rising edge.
   task automatic step(input vec_t v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
   endtask

   vec_t zero_v;

   // ---------------- main sequence ----------------
   initial begin
      zero_v = mk(0, 6'b0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h0, 2'd0,
                  5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd0);
      rst = 1'b0;
      drive(zero_v);

      //        fl st         wd    wr wdata         wh hi            lo            hilo_i                 cnt
      //        e_wd  e_wr e_wdata      e_wh e_hi          e_lo          e_hilo                 e_cnt e_bcnt
      vecs[0] = mk(0, 6'b000000, 5'd8,  1, 32'h1234_5678, 0, 32'h0,         32'h0,         64'h0000_0000_0000_DEAD, 2'd2,
                   5'd8,  1, 32'h1234_5678, 0, 32'h0,         32'h0,         64'h0,                   2'd0, 16'd0);
      vecs[1] = mk(0, 6'b001111, 5'd3,  1, 32'h0000_0005, 1, 32'h9,         32'h7,         64'h0000_0001_FFFF_FFFE, 2'd1,
                   5'd0,  0, 32'h0,         0, 32'h0,         32'h0,         64'h0000_0001_FFFF_FFFE, 2'd1, 16'd1);
      vecs[2] = mk(0, 6'b000000, 5'd31, 0, 32'hAAAA_5555, 1, 32'h1111_2222, 32'h3333_4444, 64'h0000_0000_0000_0077, 2'd3,
                   5'd31, 0, 32'hAAAA_5555, 1, 32'h1111_2222, 32'h3333_4444, 64'h0,                   2'd0, 16'd1);
      vecs[3] = mk(0, 6'b011111, 5'd1,  1, 32'h0BAD_F00D, 0, 32'h5,         32'h6,         64'h0000_0000_0000_0005, 2'd2,
                   5'd31, 0, 32'hAAAA_5555, 1, 32'h1111_2222, 32'h3333_4444, 64'h0,                   2'd0, 16'd1);
      vecs[4] = mk(0, 6'b011111, 5'd2,  1, 32'hCAFE_BABE, 0, 32'h5,         32'h6,         64'h0000_0000_0000_0006, 2'd1,
                   5'd31, 0, 32'hAAAA_5555, 1, 32'h1111_2222, 32'h3333_4444, 64'h0,                   2'd0, 16'd1);
      vecs[5] = mk(0, 6'b111111, 5'd4,  1, 32'h0101_0101, 0, 32'h5,         32'h6,         64'h0000_0000_0000_0007, 2'd1,
                   5'd31, 0, 32'hAAAA_5555, 1, 32'h1111_2222, 32'h3333_4444, 64'h0,                   2'd0, 16'd1);
      vecs[6] = mk(1, 6'b001111, 5'd6,  1, 32'h0000_0066, 1, 32'h1,         32'h2,         64'h0000_0001_0000_0001, 2'd1,
                   5'd0,  0, 32'h0,         0, 32'h0,         32'h0,         64'h0,                   2'd0, 16'd1);
      vecs[7] = mk(0, 6'b101111, 5'd9,  1, 32'h0000_0099, 1, 32'h3,         32'h4,         64'h1234_5678_9ABC_DEF0, 2'd2,
                   5'd0,  0, 32'h0,         0, 32'h0,         32'h0,         64'h1234_5678_9ABC_DEF0, 2'd2, 16'd2);
      vecs[8] = mk(1, 6'b000000, 5'd10, 1, 32'h0000_00AA, 1, 32'h3,         32'h4,         64'h0000_0000_0000_0001, 2'd1,
                   5'd0,  0, 32'h0,         0, 32'h0,         32'h0,         64'h0,                   2'd0, 16'd2);
      vecs[9] = mk(0, 6'b100111, 5'd7,  1, 32'hFFFF_FFFF, 0, 32'hFFFF_0000, 32'h0000_FFFF, 64'h0000_0000_0000_0003, 2'd3,
                   5'd7,  1, 32'hFFFF_FFFF, 0, 32'hFFFF_0000, 32'h0000_FFFF, 64'h0,                   2'd0, 16'd2);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", zero_v);
      @(negedge clk);
      rst = 1'b1;

      // Table.
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i]);
         chk_all($sformatf("vec%0d", i), vecs[i]);
      end

      // MADD/MSUB: stall cycle carries the partial product, release clears it.
      begin
         vec_t v;
         v = zero_v;
         v.stall = 6'b001111; v.hilo = 64'h0000_0003_8000_0000; v.cnt = 2'd1;
         step(v);
         chk("madd.c1.cnt_o",  64'(cnt_o), 64'd1);
         chk("madd.c1.hilo_o", hilo_o, 64'h0000_0003_8000_0000);
         chk("madd.c1.bcnt",   64'(bubble_cnt), 64'd3);
         v = zero_v;
         v.wd = 5'd12; v.wreg = 1'b0; v.whilo = 1'b1; v.hi = 32'h4; v.lo = 32'h5;
         v.hilo = 64'h0000_0003_8000_0000; v.cnt = 2'd2;
         step(v);
         chk("madd.c2.cnt_o",     64'(cnt_o), 64'd0);
         chk("madd.c2.hilo_o",    hilo_o, 64'h0);
         chk("madd.c2.mem_whilo", 64'(mem_whilo), 64'd1);
         chk("madd.c2.mem_lo",    64'(mem_lo), 64'h5);
      end

      // Asynchronous reset mid-cycle with all inputs nonzero.
      begin
         vec_t v;
         v = mk(0, 6'b000000, 5'd17, 1, 32'hDEAD_BEEF, 1, 32'h7777_7777, 32'h8888_8888,
                64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
                5'd17, 1, 32'hDEAD_BEEF, 1, 32'h7777_7777, 32'h8888_8888, 64'h0, 2'd0, 16'd3);
         step(v);
         chk_all("pre_rst", v);
         // Make hilo_o/cnt_o nonzero too before resetting.
         v.stall = 6'b001111; v.flush = 1'b1;
         v.flush = 1'b0;
         step(v);
         chk("pre_rst2.cnt_o", 64'(cnt_o), 64'd3);
         // Leave every input nonzero, including an EX/MEM hold.
         v.stall = 6'b111111; v.flush = 1'b1;
         drive(v);
         #1;
         rst = 1'b0;
         #1;
         chk_all("async_rst", zero_v);
         chk("async_rst.sat_bcnt", 64'(s_bubble_cnt), 64'd0);
         @(negedge clk);
         rst = 1'b1;
         v = zero_v;
         v.wd = 5'd9; v.wreg = 1'b1; v.wdata = 32'h0000_0055;
         drive(v);
         @(posedge clk);
         #1;
         chk("post_rst.mem_wd",    64'(mem_wd), 64'd9);
         chk("post_rst.mem_wdata", 64'(mem_wdata), 64'h55);
         chk("post_rst.bcnt",      64'(bubble_cnt), 64'd0);
      end

      // Saturation of the 4-bit counter over 20 bubbles; the 16-bit one keeps counting.
      begin
         vec_t v;
         v = zero_v;
         v.stall = 6'b001111;
         for (int i = 0; i < 20; i++) begin
            step(v);
            chk($sformatf("sat%0d.bcnt4", i), 64'(s_bubble_cnt), 64'((i + 1 > 15) ? 15 : i + 1));
            chk($sformatf("sat%0d.bcnt16", i), 64'(bubble_cnt), 64'(i + 1));
         end
         // Flush while saturated: counter holds.
         v.flush = 1'b1;
         step(v);
         chk("sat.flush.bcnt4", 64'(s_bubble_cnt), 64'd15);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
